// File: rtl/fc_vector_loader.sv
// -----------------------------------------------------------------------------
// fc_vector_loader
//
// Builds the input vector for the fully-connected `layer` neuron array. A
// serial stream of activation words is packed into an IN-element vector, which
// is presented in parallel on x for the combinational layer.
//
// Two register banks work as a ping-pong buffer. One bank fills from the
// stream while the other holds a finished frame stable for the layer and for
// whatever captures the layer output.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset
//   s_data   in   [WIDTH-1:0] activation word, element order 0..IN-1
//   s_valid  in   s_data is valid
//   s_last   in   final word of a frame (qualified by s_valid & s_ready)
//   s_ready  out  loader can accept a word this cycle
//   x        out  [WIDTH-1:0] x [0:IN-1] parallel vector to the layer
//   x_valid  out  x holds a complete frame
//   x_ready  in   consumer has taken x; releases the read bank
//   err_len  out  one-cycle pulse when a frame's length is wrong
// -----------------------------------------------------------------------------
module fc_vector_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 84
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err_len
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  // Frame storage, one register array per bank.
  logic [WIDTH-1:0] bank0 [0:IN-1];
  logic [WIDTH-1:0] bank1 [0:IN-1];

  // Control state.
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] idx;

  // Per-cycle decodes.
  logic             accept;
  logic             at_last_idx;
  logic             complete;
  logic             early_last;
  logic             missing_last;
  logic             consume;
  logic [1:0]       full_nxt;

  // s_ready depends only on registered state and rst, never on s_valid, so
  // upstream logic cannot form a combinational loop through this block.
  assign s_ready = !rst && !full[wr_sel];

  assign accept       = s_valid && s_ready;
  assign at_last_idx  = (idx == LAST_IDX);
  // The element count decides frame completion; s_last only flags errors.
  assign complete     = accept && at_last_idx;
  assign missing_last = complete && !s_last;
  assign early_last   = accept && s_last && !at_last_idx;

  // x_valid comes straight from the flag register of the bank being read.
  assign x_valid = full[rd_sel];
  assign consume = x_valid && x_ready;

  // Completion and consume always target different banks: completion needs
  // the write bank empty, consume needs the read bank full. Both updates can
  // therefore be applied in the same cycle without losing a frame.
  always_comb begin
    full_nxt = full;
    if (complete) full_nxt[wr_sel] = 1'b1;
    if (consume)  full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      idx     <= '0;
      err_len <= 1'b0;
    end else begin
      full    <= full_nxt;
      err_len <= missing_last || early_last;
      if (consume) rd_sel <= !rd_sel;
      if (accept) begin
        if (complete) begin
          wr_sel <= !wr_sel;
          idx    <= '0;
        end else if (early_last) begin
          // Short frame: drop it and refill the same bank from element 0.
          idx    <= '0;
        end else begin
          idx    <= idx + 1'b1;
        end
      end
    end
  end

  // Storage is cleared on reset so x reads as all zeros until the first frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (accept) begin
      if (wr_sel) bank1[idx] <= s_data;
      else        bank0[idx] <= s_data;
    end
  end

  // The read bank only changes on consume, so x is stable while a frame waits.
  always_comb begin
    for (int i = 0; i < IN; i++) begin
      x[i] = rd_sel ? bank1[i] : bank0[i];
    end
  end

endmodule

// File: tb/tb_fc_vector_loader.sv
module tb_fc_vector_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 84;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;
  logic             err_len;

  fc_vector_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err_len (err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitors, sampled on the falling edge.
  int err_cycles = 0;
  always @(negedge clk) if (err_len === 1'b1) err_cycles++;

  logic [WIDTH-1:0] snap [0:IN-1];
  bit stab_en = 0;
  int stab_bad = 0;
  always @(negedge clk) begin
    if (stab_en) begin
      for (int i = 0; i < IN; i++) if (x[i] !== snap[i]) stab_bad++;
    end
  end

  bit stream_en = 0;
  int stream_stall = 0;
  logic [WIDTH-1:0] seen_x5 [$];
  always @(negedge clk) begin
    if (stream_en) begin
      if (!s_ready) stream_stall++;
      if (x_valid && x_ready) seen_x5.push_back(x[5]);
    end
  end

  task automatic take_snap();
    for (int i = 0; i < IN; i++) snap[i] = x[i];
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_timeout", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // last_pos < 0 means s_last is never raised.
  task automatic send_frame(input int base, input int n, input int last_pos);
    for (int i = 0; i < n; i++) send_word(WIDTH'(base + i), (i == last_pos));
  endtask

  task automatic pulse_ready();
    x_ready = 1'b1;
    @(posedge clk);
    #1;
    x_ready = 1'b0;
  endtask

  int e0;

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; x_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_x_valid", {31'b0, x_valid}, 32'd0);
    chk("rst_err_len", {31'b0, err_len}, 32'd0);
    chk("rst_x0", {24'b0, x[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", {31'b0, s_ready}, 32'd1);
    @(posedge clk); #1;

    // Single frame 1..84, x_ready low
    send_frame(1, 83, -1);
    chk("single_pre_valid", {31'b0, x_valid}, 32'd0);
    send_word(8'd84, 1'b1);
    chk("single_valid", {31'b0, x_valid}, 32'd1);
    chk("single_x0", {24'b0, x[0]}, 32'h01);
    chk("single_x83", {24'b0, x[83]}, 32'h54);
    chk("single_err", err_cycles, 32'd0);
    pulse_ready();
    chk("single_consumed", {31'b0, x_valid}, 32'd0);

    // Back-pressure and stability
    send_frame(8'h10, IN, IN - 1);
    chk("bp_f1_valid", {31'b0, x_valid}, 32'd1);
    take_snap();
    stab_en = 1;
    send_frame(8'h20, IN, IN - 1);
    s_data = 8'h30; s_valid = 1'b1; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_s_ready_low", {31'b0, s_ready}, 32'd0);
    chk("bp_x0_held", {24'b0, x[0]}, 32'h10);
    stab_en = 0;
    chk("stable_x", stab_bad, 32'd0);
    @(posedge clk); #1;
    pulse_ready();
    @(negedge clk);
    chk("bp_x0_f2", {24'b0, x[0]}, 32'h20);
    chk("bp_valid_f2", {31'b0, x_valid}, 32'd1);
    chk("bp_ready_back", {31'b0, s_ready}, 32'd1);
    @(posedge clk); #1;   // word 0x30 accepted here
    s_valid = 1'b0;
    for (int i = 1; i < IN; i++) send_word(WIDTH'(8'h30 + i), (i == IN - 1));
    chk("bp_full_stall", {31'b0, s_ready}, 32'd0);
    chk("bp_x83_f2", {24'b0, x[83]}, 32'h73);
    pulse_ready();
    chk("bp_x0_f3", {24'b0, x[0]}, 32'h30);
    chk("bp_x83_f3", {24'b0, x[83]}, 32'h83);
    pulse_ready();
    chk("bp_drained", {31'b0, x_valid}, 32'd0);

    // Streaming with x_ready tied high
    x_ready = 1'b1;
    stream_en = 1;
    for (int f = 1; f <= 4; f++) send_frame(f * 16, IN, IN - 1);
    repeat (2) @(negedge clk);
    stream_en = 0;
    x_ready = 1'b0;
    chk("stream_stalls", stream_stall, 32'd0);
    chk("stream_count", seen_x5.size(), 32'd4);
    for (int f = 0; f < 4 && f < seen_x5.size(); f++)
      chk($sformatf("stream_x5_%0d", f), {24'b0, seen_x5[f]}, 32'((f + 1) * 16 + 5));
    chk("stream_err", err_cycles, 32'd0);
    @(posedge clk); #1;

    // Early s_last
    e0 = err_cycles;
    send_frame(8'hA0, 40, 39);
    repeat (2) @(negedge clk);
    chk("early_err_pulse", err_cycles - e0, 32'd1);
    chk("early_no_valid", {31'b0, x_valid}, 32'd0);
    @(posedge clk); #1;
    send_frame(8'h50, IN, IN - 1);
    chk("after_early_valid", {31'b0, x_valid}, 32'd1);
    chk("after_early_x0", {24'b0, x[0]}, 32'h50);
    chk("after_early_x39", {24'b0, x[39]}, 32'h77);
    chk("after_early_x83", {24'b0, x[83]}, 32'hA3);

    // Missing s_last on word 84
    e0 = err_cycles;
    send_frame(8'h60, IN, -1);
    repeat (2) @(negedge clk);
    chk("nolast_err_pulse", err_cycles - e0, 32'd1);
    @(posedge clk); #1;
    pulse_ready();
    chk("nolast_valid", {31'b0, x_valid}, 32'd1);
    chk("nolast_x0", {24'b0, x[0]}, 32'h60);
    pulse_ready();
    chk("nolast_drained", {31'b0, x_valid}, 32'd0);

    // Asynchronous reset mid-frame
    send_frame(8'h90, IN, IN - 1);
    send_frame(8'h70, 50, -1);
    chk("pre_rst_valid", {31'b0, x_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_x_valid", {31'b0, x_valid}, 32'd0);
    chk("arst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("arst_x0", {24'b0, x[0]}, 32'd0);
    chk("arst_x83", {24'b0, x[83]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    e0 = err_cycles;
    send_frame(8'h80, IN - 1, -1);
    chk("fresh_pre_valid", {31'b0, x_valid}, 32'd0);
    send_word(8'hD3, 1'b1);
    chk("fresh_valid", {31'b0, x_valid}, 32'd1);
    chk("fresh_x0", {24'b0, x[0]}, 32'h80);
    chk("fresh_x49", {24'b0, x[49]}, 32'hB1);
    chk("fresh_x83", {24'b0, x[83]}, 32'hD3);
    repeat (2) @(negedge clk);
    chk("fresh_err", err_cycles - e0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global guard against a hang.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fc_vector_loader.md
Name: fc_vector_loader

Overview:
- Producer-side counterpart of the fully-connected `layer` neuron array.
- Accepts activations serially as a valid/ready stream of WIDTH-bit words, assembles them into a complete IN-element vector, and presents that vector in parallel on `x[0:IN-1]` for the combinational layer.
- Ping-pong (two-bank) buffering lets the next frame load while the current vector is held stable for the layer and its downstream capture logic.

Parameters:
- WIDTH, 8, activation word width; matches the layer WIDTH.
- IN, 84, elements per frame; matches the layer input count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- s_data  input  WIDTH  activation word; element order index 0..IN-1.
- s_valid  input  1  s_data valid.
- s_last  input  1  marks the final word of a frame; qualified by s_valid & s_ready.
- s_ready  output  1  loader can accept a word this cycle.
- x  output  WIDTH x IN (unpacked [0:IN-1])  parallel vector to the layer.
- x_valid  output  1  x holds a complete frame.
- x_ready  input  1  consumer has taken x; frees the read bank.
- err_len  output  1  one-cycle pulse on a frame-length mismatch.

Behaviour:
- Reset, asynchronous, any time including mid-frame:
  - Both bank full flags = 0; wr_sel = 0; rd_sel = 0; idx = 0.
  - All bank storage = 0, so x = all zeros.
  - x_valid = 0, err_len = 0.
  - s_ready = 0 while rst is high.
  - Any partial frame is discarded.
- State:
  - Two banks, each IN x WIDTH registers.
  - full[1:0] flags.
  - wr_sel and rd_sel pointers.
  - idx counter of width $clog2(IN), range 0..IN-1.
- s_ready = !rst & !full[wr_sel]. Combinational from registered state only; no path from s_valid.
- Accept = s_valid & s_ready. On accept, bank[wr_sel][idx] <= s_data.
- Frame completion, on accept with idx == IN-1:
  - full[wr_sel] <= 1; wr_sel toggles; idx <= 0.
  - If s_last = 0, err_len pulses but the frame is still committed; element count is authoritative.
- Early last, on accept with s_last = 1 and idx < IN-1:
  - The word is written, the frame is abandoned, and idx <= 0.
  - full is unchanged, the bank is reused, and err_len pulses.
- x = bank[rd_sel]. x_valid = full[rd_sel], registered.
  - Latency: the last word accepted at edge N gives x_valid = 1 after edge N (cycle N+1) if that bank was next to read.
- Consume = x_valid & x_ready: full[rd_sel] <= 0 and rd_sel toggles.
  - x must stay stable while x_valid = 1 and x_ready = 0.
  - x_ready while x_valid = 0 is ignored.
- Simultaneous completion into one bank and consume of the other in the same cycle: both take effect. No frame loss; the new bank becomes readable the next cycle.
- Both banks full: s_ready = 0, and producer words are held upstream. One consume makes s_ready = 1 the next cycle.
- Ordering: frames are presented strictly in arrival order. rd_sel and wr_sel start equal and toggle once per frame.
- x_valid deasserts only via consume or reset.
- err_len is high for exactly one cycle per erroneous frame.
- Throughput: one word per cycle sustained. One frame per IN cycles when x_ready is held high.

Test Plan:
- Reset then a single frame:
  - Stimulus: words 1..84 back-to-back, s_last on word 84, x_ready = 0.
  - Response: x_valid rises the cycle after word 84 is accepted; x[0] = 1, x[83] = 84 (0x54); err_len never pulses.
- Back-pressure:
  - Stimulus: three frames (values 0x10+i, 0x20+i, 0x30+i) with x_ready = 0.
  - Response: s_ready drops after frame 2 completes; frame 3 stalls at idx 0.
  - Then: pulse x_ready for 1 cycle; x shows frame 2 (x[0] = 0x20) the next cycle; frame 3 then loads.
- Streaming:
  - Stimulus: x_ready tied high, four frames back-to-back.
  - Response: s_ready stays 1 throughout; x_valid asserts once per frame; frames appear in order with x[5] = 0x15, 0x25, 0x35, 0x45.
- Length errors:
  - s_last on word 40 -> err_len pulses 1 cycle; no x_valid; the next 84-word frame loads correctly.
  - No s_last on word 84 -> err_len pulses and x_valid still asserts.
- Async reset mid-frame:
  - Stimulus: assert rst after word 50, away from a clock edge.
  - Response: x_valid = 0, x = 0, and s_ready = 0 immediately.
  - Then: after release, a fresh 84-word frame is assembled from index 0.
- Stability:
  - Stimulus: while x_valid = 1 and x_ready = 0, stream the next frame into the other bank.
  - Response: x remains bit-identical every cycle until consume.
